monpro_row_seq: RTL and testbench

Row sequencer for the word-serial Montgomery product datapath. For one multiplier word `a`, it computes t[j] := t[j] + a·b[j] + C over all NUM_WORDS 64-bit words j, propagating the carry C, and then writes the final carry to t[NUM_WORDS]. It reads b and t from external synchronous-read memories and drives one external `mul_add` unit, holding each operand set stable for the unit's full pipeline depth. It writes each low word back to t.

---
 rtl/monpro_row_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_monpro_row_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monpro_row_seq.sv
// -----------------------------------------------------------------------------
// monpro_row_seq
//
// Row sequencer for the word-serial Montgomery product datapath. For a single
// multiplier word a it walks j = 0 .. NUM_WORDS-1 and performs
//
//     {C, t[j]} := a * b[j] + t[j] + C
//
// using an external pipelined mul_add unit, then stores the final carry in
// t[NUM_WORDS]. b and t live in external synchronous-read memories (data is
// valid the cycle after the read strobe).
//
// Per word the sequence is RD, LD, EX x MAC_LATENCY, WB (3 + MAC_LATENCY
// cycles). The mul_add operands come straight from registers and hold still
// from the first EX cycle through WB, because the unit samples x*y and
// z + last_c on different edges of its pipeline.
//
// Optional feature (macro MONPRO_CLEAR_EN):
//   Adds input `clear`, latched together with `start`, and output `b_rd_en`.
//   With clear latched high, t is never read (rd_en stays low, only b_rd_en
//   strobes) and the t operand is forced to zero, so the row computes
//   t := a * b. Without the macro there is no clear port and mac_z is always
//   the value read from t[j].
//
// Parameters:
//   NUM_WORDS    words per operand (NUM_WORDS <= 2**ADDR_W - 1)
//   ADDR_W       memory address width
//   MAC_LATENCY  edges from operand presentation to a valid mul_add result
//                (>= 2)
//   DATA_WIDTH   word width, fixed at 64
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, a_word       row request (sampled in IDLE only) and multiplier word
//   busy, done          row in progress; one-cycle completion pulse
//   rd_en               read strobe for b and t
//   b_rd_addr/t_rd_addr read addresses (j during RD, 0 otherwise)
//   b_rd_data/t_rd_data read data, valid the cycle after rd_en
//   t_we/t_wr_addr/t_wr_data  write port of t
//   mac_x/y/z/last_c    mul_add operands a, b[j], t[j], C
//   mac_s, mac_c        mul_add low / high result
//   clear, b_rd_en      only with MONPRO_CLEAR_EN (see above)
// -----------------------------------------------------------------------------
module monpro_row_seq #(
   parameter  int NUM_WORDS   = 16,
   parameter  int ADDR_W      = 5,
   parameter  int MAC_LATENCY = 3,
   localparam int DATA_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a_word,
`ifdef MONPRO_CLEAR_EN
   input  logic                  clear,
   output logic                  b_rd_en,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     b_rd_addr,
   output logic [ADDR_W-1:0]     t_rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] b_rd_data,
   input  logic [DATA_WIDTH-1:0] t_rd_data,
   output logic                  t_we,
   output logic [ADDR_W-1:0]     t_wr_addr,
   output logic [DATA_WIDTH-1:0] t_wr_data,
   output logic [DATA_WIDTH-1:0] mac_x,
   output logic [DATA_WIDTH-1:0] mac_y,
   output logic [DATA_WIDTH-1:0] mac_z,
   output logic [DATA_WIDTH-1:0] mac_last_c,
   input  logic [DATA_WIDTH-1:0] mac_s,
   input  logic [DATA_WIDTH-1:0] mac_c
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ---------------------------------------------------------------------------
   if (MAC_LATENCY < 2) begin : g_bad_latency
      $error("monpro_row_seq: MAC_LATENCY must be at least 2");
   end
   if (NUM_WORDS > (1 << ADDR_W) - 1) begin : g_bad_addr_w
      $error("monpro_row_seq: NUM_WORDS must fit below 2**ADDR_W");
   end

   // EX counter only has to reach MAC_LATENCY-1.
   localparam int CNT_W = (MAC_LATENCY > 2) ? $clog2(MAC_LATENCY) : 1;

   localparam logic [ADDR_W-1:0] LAST_J   = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] CARRY_AD = ADDR_W'(NUM_WORDS);
   localparam logic [CNT_W-1:0]  EX_LAST  = CNT_W'(MAC_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_LD   = 3'd2,
      S_EX   = 3'd3,
      S_WB   = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t state, state_next;

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] a_reg;      // multiplier word for this row
   logic [DATA_WIDTH-1:0] b_op;       // b[j] captured in LD
   logic [DATA_WIDTH-1:0] t_op;       // t[j] captured in LD
   logic [DATA_WIDTH-1:0] carry_reg;  // running carry C
   logic [ADDR_W-1:0]     j_reg;      // current word index
   logic [CNT_W-1:0]      ex_cnt;     // cycles spent in EX for this word
`ifdef MONPRO_CLEAR_EN
   logic                  clear_reg;  // row runs with t treated as zero
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: every clocked register is assigned with <= so that all flops sample
   // pre-edge values; blocking assignments here would create order-dependent
   // simulation and can mismatch the synthesized netlist.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      rd_en      = 1'b0;
      b_rd_addr  = '0;
      t_rd_addr  = '0;
      t_we       = 1'b0;
      t_wr_addr  = '0;
      t_wr_data  = '0;
`ifdef MONPRO_CLEAR_EN
      b_rd_en    = 1'b0;
`endif

      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = S_RD;
            end
         end

         S_RD: begin
            b_rd_addr = j_reg;
`ifdef MONPRO_CLEAR_EN
            // b is always fetched; t only when the row accumulates into it.
            b_rd_en   = 1'b1;
            rd_en     = ~clear_reg;
            t_rd_addr = clear_reg ? '0 : j_reg;
`else
            rd_en     = 1'b1;
            t_rd_addr = j_reg;
`endif
            state_next = S_LD;
         end

         S_LD: begin
            state_next = S_EX;
         end

         S_EX: begin
            if (ex_cnt == EX_LAST) begin
               state_next = S_WB;
            end
         end

         S_WB: begin
            // mac_s is valid exactly in this cycle; it is forwarded, not stored.
            t_we       = 1'b1;
            t_wr_addr  = j_reg;
            t_wr_data  = mac_s;
            state_next = (j_reg == LAST_J) ? S_FIN : S_RD;
         end

         S_FIN: begin
            t_we       = 1'b1;
            t_wr_addr  = CARRY_AD;
            t_wr_data  = carry_reg;
            done       = 1'b1;
            state_next = S_IDLE;
         end

         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath register updates
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_op      <= '0;
         t_op      <= '0;
         carry_reg <= '0;
         j_reg     <= '0;
         ex_cnt    <= '0;
`ifdef MONPRO_CLEAR_EN
         clear_reg <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg     <= a_word;
                  carry_reg <= '0;
                  j_reg     <= '0;
`ifdef MONPRO_CLEAR_EN
                  clear_reg <= clear;
`endif
               end
            end

            S_LD: begin
               b_op   <= b_rd_data;
`ifdef MONPRO_CLEAR_EN
               t_op   <= clear_reg ? '0 : t_rd_data;
`else
               t_op   <= t_rd_data;
`endif
               ex_cnt <= '0;
            end

            S_EX: begin
               ex_cnt <= ex_cnt + CNT_W'(1);
            end

            S_WB: begin
               // The carry changes only after the result has been consumed,
               // so last_c stays put for the whole EX..WB window.
               carry_reg <= mac_c;
               j_reg     <= j_reg + ADDR_W'(1);
            end

            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // mul_add operands: registers only, never decoded from state, so they are
   // glitch-free and constant while the unit's pipeline is consuming them.
   // ---------------------------------------------------------------------------
   assign mac_x      = a_reg;
   assign mac_y      = b_op;
   assign mac_z      = t_op;
   assign mac_last_c = carry_reg;

endmodule

// File: tb/tb_monpro_row_seq.sv
// -----------------------------------------------------------------------------
// Testbench for monpro_row_seq (NUM_WORDS=4, MAC_LATENCY=3).
//
// The bench owns the b/t memories and a pipelined mul_add model. A row model
// computes, at the moment a start is accepted, the expected low words and
// carries with plain 128-bit arithmetic, and the expected timeline from the
// row-cycle formula. One compare process checks the outputs every cycle.
// Directed rows add literal expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_monpro_row_seq;

   localparam int N    = 4;
   localparam int AW   = 5;
   localparam int L    = 3;
   localparam int P    = L + 3;     // cycles per word
   localparam int ROW  = N * P;     // cycle of the last WB after start

   logic          clk;
   logic          rst;
   logic          start;
   logic [63:0]   a_word;
   logic          clear_drv;
   logic          busy, done, rd_en, t_we;
   logic [AW-1:0] b_rd_addr, t_rd_addr, t_wr_addr;
   logic [63:0]   b_rd_data, t_rd_data, t_wr_data;
   logic [63:0]   mac_x, mac_y, mac_z, mac_last_c, mac_s, mac_c;
`ifdef MONPRO_CLEAR_EN
   logic          b_rd_en;
`endif

   monpro_row_seq #(
      .NUM_WORDS   (N),
      .ADDR_W      (AW),
      .MAC_LATENCY (L)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a_word     (a_word),
`ifdef MONPRO_CLEAR_EN
      .clear      (clear_drv),
      .b_rd_en    (b_rd_en),
`endif
      .busy       (busy),
      .done       (done),
      .b_rd_addr  (b_rd_addr),
      .t_rd_addr  (t_rd_addr),
      .rd_en      (rd_en),
      .b_rd_data  (b_rd_data),
      .t_rd_data  (t_rd_data),
      .t_we       (t_we),
      .t_wr_addr  (t_wr_addr),
      .t_wr_data  (t_wr_data),
      .mac_x      (mac_x),
      .mac_y      (mac_y),
      .mac_z      (mac_z),
      .mac_last_c (mac_last_c),
      .mac_s      (mac_s),
      .mac_c      (mac_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard counters and check tasks
   // ---------------------------------------------------------------------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Memories (synchronous read) with a bench preload port on t
   // ---------------------------------------------------------------------------
   logic [63:0]   b_mem [0:(1<<AW)-1];
   logic [63:0]   t_mem [0:(1<<AW)-1];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [63:0]   pre_data;
   int            t_rd_cnt = 0;

   always @(posedge clk) begin
`ifdef MONPRO_CLEAR_EN
      if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
`else
      if (rd_en)   b_rd_data <= b_mem[b_rd_addr];
`endif
      if (rd_en) begin
         t_rd_data <= t_mem[t_rd_addr];
         t_rd_cnt  <= t_rd_cnt + 1;
      end
      if (pre_we)    t_mem[pre_addr]  <= pre_data;
      else if (t_we) t_mem[t_wr_addr] <= t_wr_data;
   end

   // ---------------------------------------------------------------------------
   // mul_add model: x*y sampled on the first edge after presentation, z+c one
   // edge later; the result appears MAC_LATENCY edges after presentation.
   // ---------------------------------------------------------------------------
   logic [127:0] xy_pipe [0:L-1];
   logic [127:0] zc_pipe [0:L-1];

   always @(posedge clk) begin
      xy_pipe[0] <= {64'b0, mac_x} * {64'b0, mac_y};
      zc_pipe[0] <= {64'b0, mac_z} + {64'b0, mac_last_c};
      for (int i = 1; i < L; i++) begin
         xy_pipe[i] <= xy_pipe[i-1];
         zc_pipe[i] <= zc_pipe[i-1];
      end
   end

   assign {mac_c, mac_s} = xy_pipe[L-1] + zc_pipe[L-2];

   // ---------------------------------------------------------------------------
   // Row model
   // ---------------------------------------------------------------------------
   int          cyc     = 0;      // index of the current cycle
   bit          m_valid = 1'b0;
   int          m_t0    = 0;      // cycle in which the start was accepted
   bit          m_clr   = 1'b0;
   logic [63:0] m_a;
   logic [63:0] m_b   [N];
   logic [63:0] m_t   [N];
   logic [63:0] m_cin [N];
   logic [63:0] m_lo  [N];
   logic [63:0] m_top;

   always @(posedge clk) begin : row_model
      logic [127:0] acc;
      logic [63:0]  c;
      logic [63:0]  tv;
      bit           idle_now;
      idle_now = !(m_valid && cyc > m_t0 && cyc <= m_t0 + ROW + 1);
      if (rst) begin
         m_valid <= 1'b0;
      end else if (start && idle_now) begin
         m_valid <= 1'b1;
         m_t0    <= cyc;
         m_a     <= a_word;
         m_clr   <= clear_drv;
         c = 64'd0;
         for (int j = 0; j < N; j++) begin
            tv  = clear_drv ? 64'd0 : t_mem[j];
            acc = {64'b0, a_word} * {64'b0, b_mem[j]} + {64'b0, tv} + {64'b0, c};
            m_b[j]   <= b_mem[j];
            m_t[j]   <= tv;
            m_cin[j] <= c;
            m_lo[j]  <= acc[63:0];
            c = acc[127:64];
         end
         m_top <= c;
      end
      cyc <= cyc + 1;
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare against the model timeline
   // ---------------------------------------------------------------------------
   bit chk_en   = 1'b0;
   int busy_cnt = 0;
   int we_q   [$];
   int done_q [$];

   always @(negedge clk) begin : compare
      int          k, ph, jj;
      bit          act, e_rd, e_we;
      logic [63:0] e_wa, e_wd;
      if (chk_en) begin
         k    = cyc - m_t0;
         act  = m_valid && k >= 1 && k <= ROW + 1;
         e_rd = 1'b0; e_we = 1'b0; e_wa = '0; e_wd = '0; ph = 0; jj = 0;
         if (act && k <= ROW) begin
            ph   = (k - 1) % P;
            jj   = (k - 1) / P;
            e_rd = (ph == 0);
            if (ph == P - 1) begin
               e_we = 1'b1;
               e_wa = 64'(jj);
               e_wd = m_lo[jj];
            end
         end else if (act) begin
            e_we = 1'b1;
            e_wa = 64'(N);
            e_wd = m_top;
         end

         check_bit("busy", busy, act);
         check_bit("done", done, act && k == ROW + 1);
         check_bit("rd_en", rd_en, e_rd && !m_clr);
`ifdef MONPRO_CLEAR_EN
         check_bit("b_rd_en", b_rd_en, e_rd);
`endif
         check_bit("t_we", t_we, e_we);
         if (e_rd) check("b_rd_addr", 64'(b_rd_addr), 64'(jj));
         if (e_rd && !m_clr) check("t_rd_addr", 64'(t_rd_addr), 64'(jj));
         if (e_we) begin
            check("t_wr_addr", 64'(t_wr_addr), e_wa);
            check("t_wr_data", t_wr_data, e_wd);
         end
         if (act && k <= ROW && ph >= 2) begin
            check("mac_x", mac_x, m_a);
            check("mac_y", mac_y, m_b[jj]);
            check("mac_z", mac_z, m_t[jj]);
            check("mac_last_c", mac_last_c, m_cin[jj]);
         end

         if (busy) busy_cnt++;
         if (t_we) we_q.push_back(int'(t_wr_addr));
         if (done) done_q.push_back(cyc);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (all called on a falling edge)
   // ---------------------------------------------------------------------------
   logic [63:0] t_init [N+1];

   task automatic load_t();
      for (int i = 0; i <= N; i++) begin
         pre_we   = 1'b1;
         pre_addr = AW'(i);
         pre_data = t_init[i];
         @(negedge clk);
      end
      pre_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_row(input logic [63:0] a, input logic clr, output int sc, output int dc);
      busy_cnt = 0;
      we_q.delete();
      a_word    = a;
      clear_drv = clr;
      start     = 1'b1;
      sc        = cyc;
      @(negedge clk);
      start     = 1'b0;
      clear_drv = 1'b0;
      dc = -1;
      for (int i = 0; i < 200 && dc < 0; i++) begin
         if (done) dc = cyc;
         else      @(negedge clk);
      end
      if (dc < 0) check_bit("done_seen", done, 1'b1);
      @(negedge clk);
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i <= N; i++)
         check($sformatf("%s_t%0d", tag, i), t_mem[i], (i < N) ? m_lo[i] : m_top);
   endtask

   task automatic check_all_zero(input string tag);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check_bit({tag, "_done"}, done, 1'b0);
      check_bit({tag, "_rd_en"}, rd_en, 1'b0);
      check_bit({tag, "_t_we"}, t_we, 1'b0);
      check({tag, "_b_rd_addr"}, 64'(b_rd_addr), 64'd0);
      check({tag, "_t_rd_addr"}, 64'(t_rd_addr), 64'd0);
      check({tag, "_t_wr_addr"}, 64'(t_wr_addr), 64'd0);
      check({tag, "_t_wr_data"}, t_wr_data, 64'd0);
      check({tag, "_mac_x"}, mac_x, 64'd0);
      check({tag, "_mac_y"}, mac_y, 64'd0);
      check({tag, "_mac_z"}, mac_z, 64'd0);
      check({tag, "_mac_last_c"}, mac_last_c, 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int sc, dc, rd0;
      rst = 1'b1; start = 1'b0; a_word = '0; clear_drv = 1'b0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Carry ripple and cycle count
      for (int j = 0; j < N; j++) b_mem[j] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int j = 0; j <= N; j++) t_init[j] = 64'd0;
      load_t();
      run_row(64'd2, 1'b0, sc, dc);
      check("ripple_done_cyc", 64'(dc - sc), 64'd25);
      check("ripple_busy_cycles", 64'(busy_cnt), 64'd25);
      check("ripple_we_count", 64'(we_q.size()), 64'd5);
      for (int i = 0; i < we_q.size() && i <= N; i++)
         check($sformatf("ripple_we_addr%0d", i), 64'(we_q[i]), 64'(i));
      check("ripple_t0", t_mem[0], 64'hFFFF_FFFF_FFFF_FFFE);
      check("ripple_t1", t_mem[1], 64'hFFFF_FFFF_FFFF_FFFF);
      check("ripple_t2", t_mem[2], 64'hFFFF_FFFF_FFFF_FFFF);
      check("ripple_t3", t_mem[3], 64'hFFFF_FFFF_FFFF_FFFF);
      check("ripple_t4", t_mem[4], 64'd1);
      check_mem("ripple");

      // Busy rejection: starts at +5 and +25 ignored, +26 accepted
      b_mem[0] = 64'h0123_4567_89AB_CDEF; b_mem[1] = 64'hFFFF_0000_FFFF_0000;
      b_mem[2] = 64'h8000_0000_0000_0001; b_mem[3] = 64'hFEDC_BA98_7654_3210;
      t_init[0] = 64'h1111_2222_3333_4444; t_init[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      t_init[2] = 64'h0;                  t_init[3] = 64'h7FFF_FFFF_0000_0001;
      t_init[4] = 64'h0;
      load_t();
      done_q.delete();
      sc = cyc;
      for (int r = 0; r <= 60; r++) begin
         start  = (r == 0 || r == 5 || r == 25 || r == 26);
         a_word = (r == 26) ? 64'hCAFE_F00D_1234_5678 :
                  (r == 0)  ? 64'h0000_0000_0000_0003 : 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk);
      end
      start = 1'b0;
      check("reject_done_count", 64'(done_q.size()), 64'd2);
      if (done_q.size() == 2) begin
         check("reject_done1_cyc", 64'(done_q[0] - sc), 64'd25);
         check("reject_done2_cyc", 64'(done_q[1] - sc), 64'd51);
      end
      check_mem("reject");

      // Operand hold: a = 0 leaves t untouched, top carry 0
      for (int j = 0; j <= N; j++) t_init[j] = (j < N) ? 64'(j + 1) : 64'hABCD;
      load_t();
      run_row(64'd0, 1'b0, sc, dc);
      for (int j = 0; j < N; j++)
         check($sformatf("hold_t%0d", j), t_mem[j], 64'(j + 1));
      check("hold_t4", t_mem[4], 64'd0);

      // General pattern with the largest multiplier
      t_init[0] = 64'hFFFF_FFFF_FFFF_FFFF; t_init[1] = 64'h0F0F_0F0F_0F0F_0F0F;
      t_init[2] = 64'hDEAD_BEEF_0000_0001; t_init[3] = 64'h0000_0000_FFFF_FFFF;
      t_init[4] = 64'h0;
      load_t();
      run_row(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, sc, dc);
      check_mem("general");

      // Reset mid-row, then a clean row
      run_row(64'h5, 1'b0, sc, dc);    // settle t to a known model state
      busy_cnt = 0;
      we_q.delete();
      a_word = 64'h0000_0001_0000_0001;
      start  = 1'b1;
      sc     = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < sc + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_c11");
      @(negedge clk);
      check_all_zero("rst_c12");
      check("rst_we_count", 64'(we_q.size()), 64'd1);
      run_row(64'h0000_0001_0000_0001, 1'b0, sc, dc);
      check("rst_rerun_done_cyc", 64'(dc - sc), 64'd25);
      check_mem("rst_rerun");

`ifdef MONPRO_CLEAR_EN
      // Clear row: t is ignored and never read
      for (int j = 0; j < N; j++) b_mem[j] = 64'(j);
      for (int j = 0; j <= N; j++) t_init[j] = 64'h5555_5555_5555_5555;
      load_t();
      rd0 = t_rd_cnt;
      run_row(64'd1, 1'b1, sc, dc);
      check("clear_t_reads", 64'(t_rd_cnt - rd0), 64'd0);
      for (int j = 0; j < N; j++)
         check($sformatf("clear_t%0d", j), t_mem[j], 64'(j));
      check("clear_t4", t_mem[4], 64'd0);
`else
      rd0 = t_rd_cnt;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
